// File: rtl/reg_bank8x8.sv
// Eight-entry register bank with one write port and one in-place up/down counter port.
// Define REG_BANK_R0_ZERO_EN to hardwire r0 to zero.
module reg_bank8x8 #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cnt_en,
  input  logic             cnt_dir,
  input  logic [2:0]       caddr,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic             zero,
  output logic             wrap
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic             zero_q, zero_d;
  logic             wrap_q, wrap_d;
  logic             cnt_hit;
  logic [WIDTH-1:0] cnt_cur, cnt_nxt;

  // A write to the same index as the counter cancels the counter operation entirely.
  assign cnt_hit = cnt_en && !(we && (waddr == caddr));

  always_comb begin
    regs_d  = regs_q;
    zero_d  = zero_q;
    wrap_d  = 1'b0;
    cnt_cur = regs_q[caddr];
    cnt_nxt = cnt_dir ? (cnt_cur + 1'b1) : (cnt_cur - 1'b1);
    if (clr) begin
      for (int i = 0; i < 8; i++) begin
        regs_d[i] = RESET_VAL;
      end
      zero_d = (RESET_VAL == '0);
    end else begin
      if (cnt_hit) begin
        regs_d[caddr] = cnt_nxt;
        zero_d        = (cnt_nxt == '0);
        wrap_d        = cnt_dir ? (cnt_cur == '1) : (cnt_cur == '0);
      end
      if (we) begin
        regs_d[waddr] = wdata;
      end
`ifdef REG_BANK_R0_ZERO_EN
      if (cnt_hit && (caddr == 3'd0)) begin
        zero_d = 1'b1;
        wrap_d = 1'b0;
      end
`endif
    end
`ifdef REG_BANK_R0_ZERO_EN
    regs_d[0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= RESET_VAL;
      end
`ifdef REG_BANK_R0_ZERO_EN
      regs_q[0] <= '0;
`endif
      zero_q <= (RESET_VAL == '0);
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      zero_q <= zero_d;
      wrap_q <= wrap_d;
    end
  end

  assign r0   = regs_q[0];
  assign r1   = regs_q[1];
  assign r2   = regs_q[2];
  assign r3   = regs_q[3];
  assign r4   = regs_q[4];
  assign r5   = regs_q[5];
  assign r6   = regs_q[6];
  assign r7   = regs_q[7];
  assign zero = zero_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_reg_bank8x8.sv
// Self-checking bench for reg_bank8x8: directed test-plan sequences plus random traffic
// compared against an integer-arithmetic reference model.
module tb_reg_bank8x8;

  logic       clk = 1'b0;
  logic       rst_n, clr, we, cnt_en, cnt_dir;
  logic [2:0] waddr, caddr;
  logic [7:0] wdata;
  logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic       zero, wrap;
  logic [7:0] rv [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain integers 0..255
  int m [8];
  bit mzero, mwrap;

  always #5 clk = ~clk;

  reg_bank8x8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .cnt_en  (cnt_en),
    .cnt_dir (cnt_dir),
    .caddr   (caddr),
    .r0      (r0),
    .r1      (r1),
    .r2      (r2),
    .r3      (r3),
    .r4      (r4),
    .r5      (r5),
    .r6      (r6),
    .r7      (r7),
    .zero    (zero),
    .wrap    (wrap)
  );

  always_comb begin
    rv[0] = r0; rv[1] = r1; rv[2] = r2; rv[3] = r3;
    rv[4] = r4; rv[5] = r5; rv[6] = r6; rv[7] = r7;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit rs, input bit cl, input bit w, input int wa, input int wd,
                       input bit ce, input bit cd, input int ca);
    rst_n = rs; clr = cl; we = w; waddr = 3'(wa); wdata = 8'(wd);
    cnt_en = ce; cnt_dir = cd; caddr = 3'(ca);
  endtask

  function automatic void model_step();
    bit hit;
    int nv;
    if (!rst_n || clr) begin
      foreach (m[i]) m[i] = 0;
      mzero = 1'b1;
      mwrap = 1'b0;
      return;
    end
    hit   = cnt_en && !(we && waddr == caddr);
    mwrap = 1'b0;
    if (hit) begin
      nv = cnt_dir ? m[caddr] + 1 : m[caddr] - 1;
      mwrap = (nv > 255) || (nv < 0);
      nv = (nv + 256) % 256;
      m[caddr] = nv;
      mzero = (nv == 0);
    end
    if (we) m[waddr] = int'(wdata);
`ifdef REG_BANK_R0_ZERO_EN
    if (hit && caddr == 3'd0) begin
      mzero = 1'b1;
      mwrap = 1'b0;
    end
    m[0] = 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 8; i++) check_eq($sformatf("r%0d", i), 32'(rv[i]), 32'(m[i]));
    check_eq("zero", 32'(zero), 32'(mzero));
    check_eq("wrap", 32'(wrap), 32'(mwrap));
  endtask

  initial begin
    // Reset held with a pending write
    drive(0, 0, 1, 3, 8'h5A, 0, 0, 0);
    tick(); tick();
    check_eq("rst_r3", 32'(r3), 32'h00);
    check_eq("rst_zero", 32'(zero), 32'h1);
    drive(1, 0, 1, 3, 8'hA5, 0, 0, 0);
    tick();
    check_eq("wr_r3", 32'(r3), 32'hA5);

    // Write all, then read each through a selector loop
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, i, 8'h10 + i, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 8; s++) begin
`ifdef REG_BANK_R0_ZERO_EN
      check_eq($sformatf("mux%0d", s), 32'(rv[s]), (s == 0) ? 32'h00 : 32'(8'h10 + s));
`else
      check_eq($sformatf("mux%0d", s), 32'(rv[s]), 32'(8'h10 + s));
`endif
    end

    // Counter wrap on r5
    drive(1, 0, 1, 5, 8'hFE, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 1, 5);     tick();
    check_eq("inc_ff", 32'(r5), 32'hFF);
    check_eq("inc_ff_wrap", 32'(wrap), 32'h0);
    tick();
    check_eq("inc_00", 32'(r5), 32'h00);
    check_eq("inc_00_wrap", 32'(wrap), 32'h1);
    check_eq("inc_00_zero", 32'(zero), 32'h1);
    drive(1, 0, 0, 0, 0, 1, 0, 5);     tick();
    check_eq("dec_ff", 32'(r5), 32'hFF);
    check_eq("dec_ff_wrap", 32'(wrap), 32'h1);
    check_eq("dec_ff_zero", 32'(zero), 32'h0);

    // Collisions
    drive(1, 0, 1, 2, 8'h07, 0, 0, 0); tick();
    drive(1, 0, 1, 4, 8'h01, 0, 0, 0); tick();
    drive(1, 0, 1, 2, 8'h40, 1, 1, 2); tick();
    check_eq("col_same_r2", 32'(r2), 32'h40);
    check_eq("col_same_wrap", 32'(wrap), 32'h0);
    check_eq("col_same_zero", 32'(zero), 32'h0);
    drive(1, 0, 1, 2, 8'h40, 1, 0, 4); tick();
    check_eq("col_diff_r4", 32'(r4), 32'h00);
    check_eq("col_diff_zero", 32'(zero), 32'h1);

    // Clear beats write and count
    drive(1, 1, 1, 7, 8'h99, 1, 1, 6); tick();
    check_eq("clr_r7", 32'(r7), 32'h00);
    check_eq("clr_r6", 32'(r6), 32'h00);
    drive(1, 0, 1, 7, 8'h99, 0, 0, 0); tick();
    check_eq("post_clr_r7", 32'(r7), 32'h99);

    // Reset in the middle of counting
    drive(1, 0, 1, 6, 8'h03, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 0, 6);     tick();
    drive(0, 0, 0, 0, 0, 1, 0, 6);     tick();
    check_eq("rstcnt_r6", 32'(r6), 32'h00);
    check_eq("rstcnt_wrap", 32'(wrap), 32'h0);
    drive(1, 0, 0, 0, 0, 1, 0, 6);     tick();
    check_eq("rstcnt_dec", 32'(r6), 32'hFF);
    check_eq("rstcnt_dec_wrap", 32'(wrap), 32'h1);

    // Random traffic, narrow address ranges and edge values to provoke collisions and wraps
    for (int n = 0; n < 400; n++) begin
      int wd;
      wd = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00)
                                       : int'($urandom_range(0, 255));
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3), wd,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank8x8.md
# reg_bank8x8

Eight-entry, 8-bit general-purpose register bank for the RISC CPU datapath. It sits directly upstream of the 8:1 operand multiplexer: its eight register outputs drive the multiplexer's eight data inputs, and the multiplexer's `selectors` choose the operand. The bank provides one synchronous write port and one counter port, so loop counters can be incremented or decremented in place. Zero and wrap flags from the counter port go to the control unit.

## Interface

Parameters:
- `WIDTH`, 8: register width. It must match the multiplexer data width.
- `RESET_VAL`, 8'h00: value loaded into every register on reset and on `clr`.

Ports:
- `clk`  input  1: single clock. All state changes on the rising edge.
- `rst_n`  input  1: reset. Synchronous, active-low.
- `clr`  input  1: synchronous clear of all registers to `RESET_VAL`.
- `we`  input  1: write enable.
- `waddr`  input  3: write register index.
- `wdata`  input  WIDTH: write data.
- `cnt_en`  input  1: counter operation enable.
- `cnt_dir`  input  1: 1 = increment, 0 = decrement.
- `caddr`  input  3: counter register index.
- `r0`..`r7`  output  WIDTH each: registered contents. These connect to multiplexer inputs `in0`..`in7`.
- `zero`  output  1: registered. Set when the result of the last counter operation equals 0.
- `wrap`  output  1: one-cycle pulse on counter overflow or underflow.

## Operation

Reset and clear:
- `rst_n`=0 at a rising edge:
  - all `rN` are set to `RESET_VAL`;
  - `zero`=1 if `RESET_VAL`==0, else 0;
  - `wrap`=0.
- `clr`=1 (with `rst_n`=1):
  - all `rN` are set to `RESET_VAL`;
  - `zero` and `wrap` are set exactly as on reset;
  - `we` and `cnt_en` are ignored that cycle.

Write port:
- `we`=1: `r[waddr]` is set to `wdata`.

Counter port:
- `cnt_en`=1: `r[caddr]` is set to `r[caddr]` ± 1, modulo 2^WIDTH.
- Increment from 8'hFF gives 8'h00 with `wrap`=1.
- Decrement from 8'h00 gives 8'hFF with `wrap`=1.

Flags:
- `zero` updates only on cycles where a counter operation takes effect. It equals (new value == 0).
- `zero` holds its value on cycles with no counter operation, including write-only cycles.
- `wrap` is 0 on every cycle without an effective wrapping counter operation.

Priority (highest first): `rst_n`, `clr`, `we`, `cnt_en`.

Simultaneous `we` and `cnt_en`:
- Different indices (`waddr`≠`caddr`): both operations take effect in the same cycle.
- Same index: the write wins. The counter operation is discarded, and `zero` and `wrap` hold/clear as if `cnt_en`=0.

General rules:
- No read port. Reads are done by the downstream multiplexer from `r0`..`r7`.
- Registers not addressed by a write or counter operation hold their value.
- The bank has no internal state beyond the 8 registers, `zero` and `wrap`.

## Timing

- Write latency: 1 cycle. `wdata` presented with `we` at edge N appears on `rN` after edge N. The multiplexer output reflects it in the same cycle, combinationally.
- Counter latency: 1 cycle. `zero` and `wrap` are valid after the same edge as the new register value.
- Back-to-back counter operations on the same register are allowed every cycle, with no stall and no handshake.
- Reset in the middle of a sequence of counter operations: that edge's counter operation is discarded and all outputs take their reset values. Operations resume on the next edge with `rst_n`=1.
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.

## Configuration

`REG_BANK_R0_ZERO_EN`:
- Defined:
  - `r0` is hardwired to 0;
  - writes to index 0 are ignored;
  - counter operations on index 0 leave `r0` at 0, set `zero`=1 and `wrap`=0;
  - `RESET_VAL` and `clr` do not affect `r0`.
- Undefined: `r0` is an ordinary register, identical in behaviour to `r1`..`r7`.

## Test plan

- Reset: hold `rst_n`=0 for 2 cycles with `we`=1, `wdata`=8'h5A -> all `rN`=8'h00, `zero`=1, `wrap`=0. Release, write 8'hA5 to index 3 -> `r3`=8'hA5 after 1 edge, all other registers remain 8'h00.
- Write all: write 8'h10+i to index i for i=0..7. Step the multiplexer `selectors` 0..7 -> multiplexer out = 8'h10..8'h17. With `REG_BANK_R0_ZERO_EN` defined, index 0 reads 8'h00 instead.
- Counter wrap: write 8'hFE to `r5`, then increment twice -> `r5`=8'hFF (`wrap`=0, `zero`=0), then 8'h00 (`wrap`=1 for one cycle, `zero`=1). Then decrement -> `r5`=8'hFF, `wrap`=1, `zero`=0.
- Collision: `r2`=8'h07. Assert `we`, `waddr`=2, `wdata`=8'h40 together with `cnt_en`, `caddr`=2, `cnt_dir`=1 -> `r2`=8'h40, `wrap`=0, `zero` unchanged. Repeat with `caddr`=4 (`r4`=8'h01, `cnt_dir`=0) -> `r2`=8'h40, `r4`=8'h00, `zero`=1.
- Clear priority: registers loaded with nonzero values. Assert `clr` together with `we` and `cnt_en` -> all `rN`=8'h00, `zero`=1, `wrap`=0. Next cycle, with `clr`=0, a write is accepted normally.
- Reset during counting: decrement `r6` from 8'h03 on every cycle and drop `rst_n` on the second edge -> `r6`=8'h00 (reset value, not 8'h01) and `wrap`=0. Decrementing again after release gives 8'hFF with `wrap`=1.
